// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: decoder/ALU feedback and imem load port in, PC/instruction/status out.
// The master side is the controller and loader. The slave side is the fetch unit.
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              stall;
    logic              Branch;
    logic              NotBranch;
    logic              Jump;
    logic              Zero;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic [31:0]       instr;
    logic [5:0]        OpCode;
    logic              halted;
    logic [31:0]       instr_count;

    modport master (
        output stall, Branch, NotBranch, Jump, Zero,
        output imem_we, imem_waddr, imem_wdata,
        input  pc, pc_plus4, instr, OpCode, halted, instr_count
    );

    modport slave (
        input  stall, Branch, NotBranch, Jump, Zero,
        input  imem_we, imem_waddr, imem_wdata,
        output pc, pc_plus4, instr, OpCode, halted, instr_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-cycle fetch stage: PC register, word-addressed instruction memory with combinational
// read, next-PC selection (jump / conditional branch / sequential), halt detection, retire counter.
module instr_fetch_unit #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] mem [DEPTH];

    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] target;
    logic        branch_taken;

    // High PC bits are dropped, so fetch addresses alias modulo the memory depth.
    assign instr         = mem[pc_reg[ADDR_W+1:2]];
    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign branch_taken  = (bus.Branch & bus.Zero) | (bus.NotBranch & ~bus.Zero);

    always_comb begin
        target = pc_plus4;
        if (bus.Jump) begin
            target = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch_taken) begin
            target = pc_plus4 + branch_offset;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        unique case (state_reg)
            ST_RUN: begin
                if (!bus.stall) begin
                    if (instr == HALT_WORD) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = target;
                        count_next = count_reg + 32'd1;
                    end
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RUN;
            pc_reg    <= RESET_PC;
            count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
        end
    end

    // Load port is live in every state, reset included; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    assign bus.pc          = pc_reg;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr       = instr;
    assign bus.OpCode      = instr[31:26];
    assign bus.halted      = (state_reg == ST_HALT);
    assign bus.instr_count = count_reg;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized run against a behavioural model
// (word array memory, integer next-PC arithmetic).
module tb_instr_fetch_unit;
    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000),
        .HALT_WORD(HALT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_count;
    bit          m_halted;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    function automatic logic [31:0] m_instr();
        return m_mem[m_pc[ADDR_W+1:2]];
    endfunction

    task automatic set_ctl(input bit st, input bit b, input bit nb, input bit j, input bit z);
        bus.stall = st; bus.Branch = b; bus.NotBranch = nb; bus.Jump = j; bus.Zero = z;
    endtask

    // One clock edge: model computes its next state from the specification rules.
    task automatic tick();
        logic [31:0] ci, tgt;
        int          imm;
        ci = m_instr();
        if (bus.Jump) begin
            tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ((ci & 32'h03FF_FFFF) * 32'd4);
        end else if ((bus.Branch && bus.Zero) || (bus.NotBranch && !bus.Zero)) begin
            imm = int'($signed(ci[15:0]));
            tgt = m_pc + 32'd4 + 32'(imm * 4);
        end else begin
            tgt = m_pc + 32'd4;
        end
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h0; m_halted = 0; m_count = 0;
        end else if (!m_halted && !bus.stall) begin
            if (ci == HALT) m_halted = 1;
            else begin
                m_pc    = tgt;
                m_count = m_count + 32'd1;
            end
        end
        if (bus.imem_we) m_mem[bus.imem_waddr] = bus.imem_wdata;
        cyc++;
        #1;
        $display("cyc %0d rst=%0b st=%0b b=%0b nb=%0b j=%0b z=%0b we=%0b -> pc=%h instr=%h halted=%0b count=%0d",
                 cyc, reset, bus.stall, bus.Branch, bus.NotBranch, bus.Jump, bus.Zero,
                 bus.imem_we, bus.pc, bus.instr, bus.halted, bus.instr_count);
    endtask

    task automatic write_word(input int addr, input logic [31:0] data);
        bus.imem_we = 1'b1; bus.imem_waddr = ADDR_W'(addr); bus.imem_wdata = data;
        tick();
        bus.imem_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_ctl(0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) write_word(i, 32'h0);
        write_word(0, 32'h8C01_0000);
        write_word(1, 32'h1000_FFFE);
        write_word(2, 32'h0022_1820);
        write_word(3, 32'hAC03_0004);
        do_reset();
        n_cmp++; if (bus.pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
        n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        n_cmp++; if (bus.instr_count !== 32'h0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.instr_count); end
        n_cmp++; if (bus.instr !== 32'h8C01_0000) begin n_err++; $display("FAIL reset_instr got=%h exp=%h", bus.instr, 32'h8C01_0000); end
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            n_cmp++; if (bus.OpCode !== m_instr()[31:26]) begin n_err++; $display("FAIL seq_opcode got=%b exp=%b", bus.OpCode, m_instr()[31:26]); end
            n_cmp++; if (bus.pc_plus4 !== m_pc + 32'd4) begin n_err++; $display("FAIL seq_pc_plus4 got=%h exp=%h", bus.pc_plus4, m_pc + 32'd4); end
            tick();
            n_cmp++; if (bus.pc !== 32'(4 * k)) begin n_err++; $display("FAIL seq_pc got=%h exp=%h", bus.pc, 32'(4 * k)); end
        end
        n_cmp++; if (bus.instr_count !== 32'd3) begin n_err++; $display("FAIL seq_count got=%0d exp=3", bus.instr_count); end
    endtask

    task automatic test_branch();
        do_reset();
        tick();
        set_ctl(0, 1, 0, 0, 1);
        tick();
        n_cmp++; if (bus.pc !== 32'h0) begin n_err++; $display("FAIL beq_taken got=%h exp=%h", bus.pc, 32'h0); end
        set_ctl(0, 0, 0, 0, 0);
        tick();
        set_ctl(0, 1, 0, 0, 0);
        tick();
        n_cmp++; if (bus.pc !== 32'h8) begin n_err++; $display("FAIL beq_not_taken got=%h exp=%h", bus.pc, 32'h8); end
        set_ctl(0, 0, 0, 0, 0);
    endtask

    task automatic test_bne_jump();
        write_word(0, 32'h0800_0004);
        write_word(4, 32'h1400_0003);
        write_word(8, 32'h0800_0040);
        write_word(64, 32'h0800_0010);
        do_reset();
        set_ctl(0, 0, 0, 1, 0); tick();
        n_cmp++; if (bus.pc !== 32'h10) begin n_err++; $display("FAIL jump_to_10 got=%h exp=%h", bus.pc, 32'h10); end
        set_ctl(0, 0, 1, 0, 0); tick();
        n_cmp++; if (bus.pc !== 32'h20) begin n_err++; $display("FAIL bne_taken got=%h exp=%h", bus.pc, 32'h20); end
        set_ctl(0, 0, 0, 1, 0); tick();
        n_cmp++; if (bus.pc !== 32'h100) begin n_err++; $display("FAIL jump_to_100 got=%h exp=%h", bus.pc, 32'h100); end
        set_ctl(0, 1, 0, 1, 1); tick();
        n_cmp++; if (bus.pc !== 32'h40) begin n_err++; $display("FAIL jump_over_branch got=%h exp=%h", bus.pc, 32'h40); end
        n_cmp++; if (bus.instr_count !== 32'd4) begin n_err++; $display("FAIL jump_count got=%0d exp=4", bus.instr_count); end
        // Reset with a jump request still asserted: the jump must be discarded.
        set_ctl(0, 0, 0, 1, 0);
        do_reset();
        n_cmp++; if (bus.pc !== 32'h0 || bus.instr_count !== 32'h0 || bus.halted !== 1'b0) begin
            n_err++; $display("FAIL midrun_reset got pc=%h count=%0d halted=%b exp pc=0 count=0 halted=0", bus.pc, bus.instr_count, bus.halted);
        end
        set_ctl(0, 0, 0, 0, 0);
        write_word(1, 32'h0800_0100);
        do_reset();
        tick();
        set_ctl(0, 0, 0, 1, 0); tick();
        set_ctl(0, 0, 0, 0, 0); #1;
        n_cmp++; if (bus.pc !== 32'h400) begin n_err++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc, 32'h400); end
        n_cmp++; if (bus.instr !== 32'h0800_0004) begin n_err++; $display("FAIL wrap_alias_instr got=%h exp=%h", bus.instr, 32'h0800_0004); end
        n_cmp++; if (bus.pc_plus4 !== 32'h404) begin n_err++; $display("FAIL wrap_pc_plus4 got=%h exp=%h", bus.pc_plus4, 32'h404); end
    endtask

    task automatic test_stall_halt();
        write_word(0, 32'h0); write_word(1, 32'h0); write_word(2, HALT);
        do_reset();
        set_ctl(1, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (bus.pc !== 32'h0 || bus.instr_count !== 32'h0) begin
                n_err++; $display("FAIL stall_hold got pc=%h count=%0d exp pc=0 count=0", bus.pc, bus.instr_count);
            end
        end
        set_ctl(0, 0, 0, 0, 0);
        tick(); tick();
        n_cmp++; if (bus.instr !== HALT || bus.halted !== 1'b0) begin
            n_err++; $display("FAIL pre_halt got instr=%h halted=%b exp instr=%h halted=0", bus.instr, bus.halted, HALT);
        end
        tick();
        n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL halt_set got=%b exp=1", bus.halted); end
        for (int k = 0; k < 5; k++) begin
            set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            n_cmp++; if (bus.pc !== 32'h8 || bus.instr_count !== 32'd2 || bus.halted !== 1'b1) begin
                n_err++; $display("FAIL halt_hold got pc=%h count=%0d halted=%b exp pc=8 count=2 halted=1", bus.pc, bus.instr_count, bus.halted);
            end
        end
        do_reset();
        n_cmp++; if (bus.halted !== 1'b0 || bus.pc !== 32'h0) begin
            n_err++; $display("FAIL halt_reset got pc=%h halted=%b exp pc=0 halted=0", bus.pc, bus.halted);
        end
        set_ctl(0, 0, 0, 0, 0);
    endtask

    task automatic test_write_port();
        write_word(0, 32'h0); write_word(1, 32'h0); write_word(2, 32'h0);
        write_word(3, 32'h0123_4567);
        do_reset();
        tick(); tick(); tick();
        set_ctl(1, 0, 0, 0, 0);
        bus.imem_we = 1'b1; bus.imem_waddr = ADDR_W'(3); bus.imem_wdata = 32'h2008_0005;
        #1;
        n_cmp++; if (bus.pc !== 32'hC || bus.instr !== 32'h0123_4567) begin
            n_err++; $display("FAIL rdw_old got pc=%h instr=%h exp pc=c instr=01234567", bus.pc, bus.instr);
        end
        tick();
        bus.imem_we = 1'b0;
        set_ctl(0, 0, 0, 0, 0);
        n_cmp++; if (bus.instr !== 32'h2008_0005) begin n_err++; $display("FAIL rdw_new got=%h exp=%h", bus.instr, 32'h2008_0005); end
        n_cmp++; if (bus.OpCode !== 6'b001000) begin n_err++; $display("FAIL rdw_opcode got=%b exp=%b", bus.OpCode, 6'b001000); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            if ($urandom_range(31) == 0) w = HALT;
            write_word(i, w);
        end
        reset = 1'b0;
        for (int k = 0; k < 400; k++) begin
            set_ctl($urandom_range(3) == 0, 1'($urandom), 1'($urandom), $urandom_range(3) == 0, 1'($urandom));
            reset = ($urandom_range(49) == 0);
            bus.imem_we = ($urandom_range(7) == 0);
            bus.imem_waddr = ADDR_W'($urandom);
            bus.imem_wdata = ($urandom_range(15) == 0) ? HALT : 32'($urandom);
            #1;
            n_cmp++; if (bus.instr !== m_instr() || bus.OpCode !== m_instr()[31:26] || bus.pc_plus4 !== m_pc + 32'd4) begin
                n_err++; $display("FAIL rand_comb got instr=%h op=%b pc4=%h exp instr=%h op=%b pc4=%h",
                                  bus.instr, bus.OpCode, bus.pc_plus4, m_instr(), m_instr()[31:26], m_pc + 32'd4);
            end
            tick();
            n_cmp++; if (bus.pc !== m_pc || bus.instr_count !== m_count || bus.halted !== m_halted) begin
                n_err++; $display("FAIL rand_state got pc=%h count=%0d halted=%b exp pc=%h count=%0d halted=%b",
                                  bus.pc, bus.instr_count, bus.halted, m_pc, m_count, m_halted);
            end
        end
        reset = 1'b0;
        bus.imem_we = 1'b0;
        set_ctl(0, 0, 0, 0, 0);
    endtask

    initial begin
        m_pc = 32'h0; m_count = 32'h0; m_halted = 0;
        reset = 1'b1;
        set_ctl(0, 0, 0, 0, 0);
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_sequential();
        test_branch();
        test_bne_jump();
        test_stall_halt();
        test_write_port();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Single-cycle datapath fetch stage, directly upstream of the main control decoder.
- Holds the program counter and a word-addressed instruction memory with combinational read and a synchronous load port.
- Presents the current instruction and its opcode field to the decoder.
- Takes the decoder's Branch/NotBranch/Jump outputs plus the ALU zero flag back in the same cycle and computes the next PC.
- Also provides the PC+4 link value for jal, a halt flag, and a retired-instruction counter.

Parameters:
- ADDR_W, 8: instruction memory address width in words; depth = 2^ADDR_W.
- RESET_PC, 32'h00000000: PC value after reset. Must be word aligned.
- HALT_WORD, 32'hFFFFFFFF: instruction encoding that halts fetch.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC for this cycle
- Branch  input  1  beq taken-if-zero request from main control
- NotBranch  input  1  bne taken-if-nonzero request from main control
- Jump  input  1  j/jal request from main control
- Zero  input  1  ALU zero flag
- imem_we  input  1  instruction memory write enable
- imem_waddr  input  ADDR_W  word address for the write
- imem_wdata  input  32  word to write
- pc  output  32  current PC
- pc_plus4  output  32  pc + 4, the link value for jal
- instr  output  32  instruction at pc
- OpCode  output  6  instr[31:26]
- halted  output  1  fetch stopped on HALT_WORD
- instr_count  output  32  number of PC advances since reset

Behaviour:
- Reset (synchronous, active-high): on a clk edge with reset=1, pc <= RESET_PC, halted <= 0, instr_count <= 0. Reset wins over every other input. Memory contents are not cleared.
- Read path: instr = mem[pc[ADDR_W+1:2]], combinational. PC bits above ADDR_W+1 are ignored, so addresses alias and wrap modulo depth. pc[1:0] is always 0.
- Combinational outputs: pc_plus4 = pc + 4 (32-bit, wraps at 2^32). OpCode = instr[31:26].
- Next-PC selection, in priority order:
  1. Jump=1: target = {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. (Branch & Zero) | (NotBranch & ~Zero): target = pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}). Sign-extended offset; the 32-bit add wraps.
  3. Otherwise: target = pc_plus4.
  - Jump together with any branch request: Jump wins.
  - Branch and NotBranch both high: taken regardless of Zero.
- Update rule at each clk edge (reset=0):
  - halted=1: pc and instr_count hold.
  - else if stall=1: pc and instr_count hold.
  - else if instr == HALT_WORD: halted <= 1; pc and instr_count hold.
  - else: pc <= target; instr_count <= instr_count + 1 (wraps at 2^32).
- Halt exit: halted clears only on reset.
- Memory write: when imem_we=1, mem[imem_waddr] <= imem_wdata at the clk edge. Writes are accepted in every state, including reset and halted.
  - Read-during-write to the same address returns the old word in that cycle and the new word from the next cycle.
- Latency: the new pc is visible one cycle after the edge. instr, OpCode and pc_plus4 follow pc combinationally in the same cycle.
- Reset asserted mid-run: pc returns to RESET_PC on that edge, and any in-flight branch or jump is discarded.

Test Plan:
- Sequential fetch: load words 0..3 via the write port, reset, run 3 cycles with all controls low -> pc = 0, 4, 8, 12; instr_count = 3; OpCode matches instr[31:26] each cycle.
- beq taken and not taken: instr at 0x4 has imm 16'hFFFE. Branch=1, Zero=1 -> next pc = 0x8 + (-8) = 0x0. Same with Zero=0 -> next pc = 0x8.
- bne and jump: NotBranch=1, Zero=0, imm 16'h0003 at pc 0x10 -> next pc = 0x20. Jump=1 with instr[25:0] = 26'h40 at pc 0x20 -> next pc = 0x100. Jump=1 and Branch=1, Zero=1 together -> jump target is taken.
- Stall and halt: stall=1 for 2 cycles -> pc and instr_count unchanged. HALT_WORD at 0x8 -> halted=1 after the edge; pc stays 0x8 for 5 further cycles while control inputs toggle.
- Reset mid-run and wrap: while halted or running at pc 0x40, assert reset 1 cycle -> pc = RESET_PC, halted = 0, instr_count = 0. With ADDR_W=8, pc 0x400 fetches the same word as pc 0x0.
- Write port: write 32'h20080005 to address 3 while pc = 0xC -> instr shows the old word that cycle and 32'h20080005 on the next cycle (OpCode = 6'b001000).
